dmem_responder: RTL and testbench

Data-memory responder for the multi-cycle MIPS core: the target end of the core's load/store port. It accepts one request at a time over a valid/ready handshake, holds it for a fixed number of wait cycles, performs the read or write on an internal word array, and returns a response over a second valid/ready handshake. It replaces the zero-latency data RAM so the core's stall logic can be exercised against realistic memory timing.

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory target for the multi-cycle MIPS core: one request at a time, fixed wait, then response.
// Define DMEM_BYTE_EN to honour req_be on stores; otherwise every store writes the full word.
module dmem_responder #(
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_cnt;
  logic                r_write;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic [31:0]         r_mem [DEPTH];
  logic [31:0]         r_rdata;
  logic                r_err;
  logic                w_accept, w_fire, w_done, w_err;
  logic [ADDR_W-1:0]   w_idx;
  logic [3:0]          w_be;

  assign w_idx     = r_addr[ADDR_W+1:2];
  assign w_err     = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_W+2] != '0);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

`ifdef DMEM_BYTE_EN
  assign w_be = r_be;
`else
  logic w_unused_be;
  assign w_unused_be = ^r_be;
  assign w_be        = 4'hF;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    w_accept  = 1'b0;
    w_fire    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_fire = 1'b1;
          w_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              r_cnt <= 3'd0;
    else if (w_accept)                      r_cnt <= CNT_INIT;
    else if (r_state == WAIT && r_cnt != 0) r_cnt <= r_cnt - 3'd1;
  end

  // Request fields are frozen at acceptance; the core may change its inputs afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_fire) begin
      r_err   <= w_err;
      r_rdata <= (w_err || r_write) ? 32'd0 : r_mem[w_idx];
    end else if (w_done) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_fire && r_write && !w_err) begin
      for (int k = 0; k < 4; k++)
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= r_wdata[8*k +: 8];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset corner sequences, randomized traffic vs. a word-array model.
module tb_dmem_responder;
  localparam int AW    = 5;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic        clock, reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int t_acc  = 0;
  int prev_acc = 0;

  logic [31:0] mem [DEPTH];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    int          stall;
    bit          hold;
    bit          gap;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
  endtask

  // Reference: a misaligned or beyond-array byte address errors; stores merge enabled bytes.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] er, output logic ee);
    logic [31:0] m;
    logic [3:0]  eb;
    int          idx;
`ifdef DMEM_BYTE_EN
    eb = be;
`else
    eb = 4'hF;
`endif
    ee  = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    er  = 32'd0;
    idx = int'(a / 4) % DEPTH;
    if (!ee) begin
      if (w) begin
        m = 32'd0;
        for (int k = 0; k < 4; k++) if (eb[k]) m = m | (32'hFF << (8 * k));
        mem[idx] = (mem[idx] & ~m) | (wd & m);
      end else begin
        er = mem[idx];
      end
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input int stall, input bit hold, input bit gap,
                     input logic [31:0] er, input logic ee);
    int n;
    logic [31:0] held;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be; rsp_ready = 1'b0;
    @(posedge clock); #1;
    prev_acc = t_acc;
    t_acc    = cyc;
    if (gap) chk("accept_spacing", t_acc - prev_acc, LAT + 2);
    if (hold) begin
      req_write = ~w; req_addr = ~a; req_wdata = ~wd; req_be = ~be;
    end else begin
      req_valid = 1'b0;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clock); #1; n++; end
    chk("latency", n, LAT);
    chk("rsp_rdata", rsp_rdata, er);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
    held = rsp_rdata;
    repeat (stall) begin
      @(posedge clock); #1;
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rdata", rsp_rdata, held);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clock);
    rsp_ready = 1'b1;
    chk("hs_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_hs_rdata", rsp_rdata, 32'd0);
    chk("post_hs_err", {31'd0, rsp_err}, 32'd0);
    chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({nm, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
  endtask

  localparam logic [31:0] MERGED = `ifdef DMEM_BYTE_EN 32'hDE22BE44 `else 32'h11223344 `endif ;
  localparam logic [31:0] BE0_RD = `ifdef DMEM_BYTE_EN 32'h00000000 `else 32'hCAFEF00D `endif ;

  initial begin
    logic [31:0] er, a, wd;
    logic        ee, w;
    logic [3:0]  be;
    int          n;

    tbl[0]  = '{1'b0, 32'h10, 32'h0,        4'hF, 0, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 32'h08, 32'h0,        4'hF, 5, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 32'h08, 32'h11223344, 4'h5, 0, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h08, 32'h0,        4'hF, 0, 1'b0, 1'b0, MERGED,       1'b0};
    tbl[5]  = '{1'b0, 32'h06, 32'h0,        4'hF, 0, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[6]  = '{1'b0, 32'h80, 32'h0,        4'hF, 0, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[7]  = '{1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[8]  = '{1'b1, 32'h0A, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[9]  = '{1'b0, 32'h08, 32'h0,        4'hF, 0, 1'b0, 1'b0, MERGED,       1'b0};
    tbl[10] = '{1'b1, 32'h7C, 32'hCAFEF00D, 4'h0, 0, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'h7C, 32'h0,        4'hF, 0, 1'b0, 1'b0, BE0_RD,       1'b0};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = 4'h0; rsp_ready = 1'b0;
    model_clear();
    #1;
    chk_reset_outputs("reset_init");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      model(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be, er, ee);
      txn(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].stall, tbl[i].hold, tbl[i].gap,
          tbl[i].er, tbl[i].ee);
    end

    // Reset in the middle of WAIT: store is dropped, outputs return to reset values at once.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h04; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("midwait_req_ready", {31'd0, req_ready}, 32'd0);
    #3 reset = 1'b1;
    #1 chk_reset_outputs("reset_midwait");
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    txn(1'b0, 32'h04, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    txn(1'b0, 32'h08, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset while a load response is pending: the response disappears.
    model(1'b1, 32'h0C, 32'hAABBCCDD, 4'hF, er, ee);
    txn(1'b1, 32'h0C, 32'hAABBCCDD, 4'hF, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0C;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clock); #1; n++; end
    chk("resp_reset_latency", n, LAT);
    chk("resp_reset_rdata", rsp_rdata, 32'hAABBCCDD);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("reset_inresp");
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    @(posedge clock); #1;
    chk("inresp_no_revive", {31'd0, rsp_valid}, 32'd0);
    txn(1'b0, 32'h0C, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0: a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        1: begin a = $urandom & 32'hFFFFFFFC; if (a < 32'(DEPTH * 4)) a = a | 32'h80000000; end
        default: a = 32'($urandom_range(0, 7)) << 2;
      endcase
      model(w, a, wd, be, er, ee);
      txn(w, a, wd, be, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, er, ee);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
